// File: rtl/ix_matrix_req_gen_if.sv
// Bundle of write, request/ack and status signals for ix_matrix_req_gen.
// master = the request generator, slave = the upstream writer / responder side.
interface ix_matrix_req_gen_if #(
  parameter int ROWS = 8,
  parameter int COLS = 8
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int PW = $clog2(ROWS * COLS + 1);

  logic                 wr_valid;
  logic                 wr_ready;
  logic [RW-1:0]        wr_row;
  logic [CW-1:0]        wr_col;
  logic                 wr_set;
  logic                 req;
  logic [RW-1:0]        req_row;
  logic [CW-1:0]        req_col;
  logic                 ack;
  logic [ROWS*COLS-1:0] ix;
  logic [PW-1:0]        pending_cnt;
  logic                 timeout_err;

  modport master (
    input  wr_valid, wr_row, wr_col, wr_set, ack,
    output wr_ready, req, req_row, req_col, ix, pending_cnt, timeout_err
  );

  modport slave (
    output wr_valid, wr_row, wr_col, wr_set, ack,
    input  wr_ready, req, req_row, req_col, ix, pending_cnt, timeout_err
  );
endinterface

// File: rtl/ix_matrix_req_gen.sv
// Raster-scans a pending-event bit matrix and raises req/ack handshakes per set bit.
// Define IX_REQ_ASSERT_EN to compile the embedded protocol assertions.
module ix_matrix_req_gen #(
  parameter int ROWS        = 8,
  parameter int COLS        = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ix_matrix_req_gen_if.master  bus
);
  localparam int CW = $clog2(COLS);
  localparam int N  = ROWS * COLS;
  localparam int NW = $clog2(N);
  localparam int PW = $clog2(N + 1);

  typedef enum logic {SCAN, REQ} state_t;

  // Sizes are powers of two, so {row,col} is the flat index r*COLS+c and a plain
  // increment of it walks raster order, wrapping (ROWS-1,COLS-1) back to (0,0).
  state_t          state, state_next;
  logic [NW-1:0]   ptr, ptr_next;
  logic [NW-1:0]   req_idx, req_idx_next;
  logic [7:0]      tmo_cnt, tmo_cnt_next;
  logic [N-1:0]    ix_q, ix_next;
  logic [PW-1:0]   pend_q, pend_next;
  logic [NW-1:0]   wr_idx;
  logic            wr_ready_c, wr_fire, ack_fire, tmo_fire;

  assign wr_idx     = {bus.wr_row, bus.wr_col};
  // The bit under an open request may not be cleared by upstream.
  assign wr_ready_c = rst_n && !(state == REQ && wr_idx == req_idx && !bus.wr_set);
  assign wr_fire    = bus.wr_valid && wr_ready_c;
  assign ack_fire   = (state == REQ) && bus.ack;
  assign tmo_fire   = (state == REQ) && !bus.ack && (tmo_cnt == 8'(ACK_TIMEOUT - 1));

  always_comb begin
    // NOTE: every signal gets a default first so no path through this block infers a latch.
    state_next   = state;
    ptr_next     = ptr;
    req_idx_next = req_idx;
    tmo_cnt_next = tmo_cnt;
    ix_next      = ix_q;

    case (state)
      SCAN: begin
        if (ix_q[ptr]) begin
          req_idx_next = ptr;
          tmo_cnt_next = '0;
          state_next   = REQ;
        end else begin
          ptr_next = ptr + NW'(1);
        end
      end
      REQ: begin
        tmo_cnt_next = tmo_cnt + 8'd1;
        if (ack_fire || tmo_fire) begin
          ptr_next   = ptr + NW'(1);
          state_next = SCAN;
        end
      end
      default: state_next = SCAN;
    endcase

    if (ack_fire) ix_next[req_idx] = 1'b0;
    // Applied after the ack clear so a same-cycle set to the same cell wins.
    if (wr_fire)  ix_next[wr_idx]  = bus.wr_set;

    pend_next = PW'($countones(ix_next));
  end

  // NOTE: the matrix is plain flops rather than a RAM, so clearing it in reset is legitimate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SCAN;
      ptr     <= '0;
      req_idx <= '0;
      tmo_cnt <= '0;
      ix_q    <= '0;
      pend_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state   <= state_next;
      ptr     <= ptr_next;
      req_idx <= req_idx_next;
      tmo_cnt <= tmo_cnt_next;
      ix_q    <= ix_next;
      pend_q  <= pend_next;
    end
  end

  assign bus.wr_ready    = wr_ready_c;
  assign bus.req         = (state == REQ);
  assign bus.req_row     = req_idx[NW-1:CW];
  assign bus.req_col     = req_idx[CW-1:0];
  assign bus.ix          = ix_q;
  assign bus.pending_cnt = pend_q;
  assign bus.timeout_err = tmo_fire;

`ifdef IX_REQ_ASSERT_EN
  // The hold check exempts the timeout cycle, where req is meant to drop.
  a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
    bus.req && !bus.ack && !bus.timeout_err |=> bus.req && $stable({bus.req_row, bus.req_col}))
    else $error("req dropped or moved while waiting for ack at row %0d col %0d",
                bus.req_row, bus.req_col);

  a_req_bit: assert property (@(posedge clk) disable iff (!rst_n)
    bus.req |-> ix_q[req_idx])
    else $error("req raised on a clear bit at row %0d col %0d", bus.req_row, bus.req_col);

  a_tmo_no_ack: assert property (@(posedge clk) disable iff (!rst_n)
    bus.timeout_err |-> !bus.ack)
    else $error("timeout_err with ack at row %0d col %0d", bus.req_row, bus.req_col);

  a_pend_cnt: assert property (@(posedge clk) disable iff (!rst_n)
    pend_q == PW'($countones(ix_q)))
    else $error("pending_cnt out of step with ix near row %0d col %0d",
                bus.req_row, bus.req_col);
`else
  // Assertions excluded from this build.
`endif
endmodule

// File: tb/tb_ix_matrix_req_gen.sv
// Directed bench for ix_matrix_req_gen: reset, handshake, raster order, timeout,
// write collision, idle scan and mid-request reset.
module tb_ix_matrix_req_gen;
  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int ACK_TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ix_matrix_req_gen_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

  ix_matrix_req_gen #(.ROWS(ROWS), .COLS(COLS), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic clear_inputs;
    bus.wr_valid = 1'b0;
    bus.wr_row   = '0;
    bus.wr_col   = '0;
    bus.wr_set   = 1'b0;
    bus.ack      = 1'b0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic do_write(input int r, input int c, input bit s);
    bus.wr_valid = 1'b1;
    bus.wr_row   = 3'(r);
    bus.wr_col   = 3'(c);
    bus.wr_set   = s;
    @(posedge clk);
    #1 bus.wr_valid = 1'b0;
  endtask

  task automatic wait_req(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.req === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic ack_now;
    bus.ack = 1'b1;
    @(posedge clk);
    #1 bus.ack = 1'b0;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (bus.wr_ready !== 1'b0) begin bad++; $display("FAIL rst_wr_ready_low got=%0b want=0", bus.wr_ready); end
    total++; if (bus.req !== 1'b0) begin bad++; $display("FAIL rst_req_low got=%0b want=0", bus.req); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    total++; if (bus.ix !== 64'h0) begin bad++; $display("FAIL rst_ix got=%h want=0", bus.ix); end
    total++; if (bus.req !== 1'b0) begin bad++; $display("FAIL rst_req got=%0b want=0", bus.req); end
    total++; if (bus.pending_cnt !== 7'd0) begin bad++; $display("FAIL rst_pending got=%0d want=0", bus.pending_cnt); end
    total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL rst_wr_ready got=%0b want=1", bus.wr_ready); end
    total++; if (bus.timeout_err !== 1'b0) begin bad++; $display("FAIL rst_timeout got=%0b want=0", bus.timeout_err); end
  endtask

  task automatic test_single;
    bit ok;
    logic [63:0] exp_ix;
    exp_ix = 64'd1 << 21;
    @(posedge clk);
    #1 do_write(2, 5, 1'b1);
    total++; if (bus.ix !== exp_ix) begin bad++; $display("FAIL single_ix_set got=%h want=%h", bus.ix, exp_ix); end
    total++; if (bus.pending_cnt !== 7'd1) begin bad++; $display("FAIL single_pending_1 got=%0d want=1", bus.pending_cnt); end
    wait_req(80, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL single_req_seen got=%0b want=1", ok); end
    total++; if ({bus.req_row, bus.req_col} !== {3'd2, 3'd5}) begin bad++; $display("FAIL single_req_pos got=(%0d,%0d) want=(2,5)", bus.req_row, bus.req_col); end
    repeat (2) @(posedge clk);
    #1 bus.ack = 1'b1;
    @(negedge clk);
    total++; if (bus.req !== 1'b1) begin bad++; $display("FAIL single_req_held got=%0b want=1", bus.req); end
    @(posedge clk);
    #1 bus.ack = 1'b0;
    @(negedge clk);
    total++; if (bus.req !== 1'b0) begin bad++; $display("FAIL single_req_drop got=%0b want=0", bus.req); end
    total++; if (bus.ix !== 64'h0) begin bad++; $display("FAIL single_ix_clear got=%h want=0", bus.ix); end
    total++; if (bus.pending_cnt !== 7'd0) begin bad++; $display("FAIL single_pending_0 got=%0d want=0", bus.pending_cnt); end
  endtask

  task automatic test_raster;
    bit ok;
    int exp_r[3] = '{0, 3, 7};
    int exp_c[3] = '{1, 0, 7};
    do_reset();
    do_write(0, 0, 1'b1);
    wait_req(80, ok);
    total++; if (ok !== 1'b1 || {bus.req_row, bus.req_col} !== 6'd0) begin bad++; $display("FAIL raster_anchor got=(%0d,%0d) ok=%0b want=(0,0)", bus.req_row, bus.req_col, ok); end
    // Ptr is frozen on (0,0) while these land, so scanning resumes from (0,1).
    do_write(7, 7, 1'b1);
    do_write(0, 1, 1'b1);
    do_write(3, 0, 1'b1);
    total++; if (bus.pending_cnt !== 7'd4) begin bad++; $display("FAIL raster_pending_4 got=%0d want=4", bus.pending_cnt); end
    ack_now();
    for (int i = 0; i < 3; i++) begin
      wait_req(80, ok);
      total++;
      if (ok !== 1'b1 || bus.req_row !== 3'(exp_r[i]) || bus.req_col !== 3'(exp_c[i])) begin
        bad++;
        $display("FAIL raster_order_%0d got=(%0d,%0d) ok=%0b want=(%0d,%0d)", i, bus.req_row, bus.req_col, ok, exp_r[i], exp_c[i]);
      end
      ack_now();
    end
    total++; if (bus.ix !== 64'h0) begin bad++; $display("FAIL raster_ix_clear got=%h want=0", bus.ix); end
  endtask

  task automatic test_timeout;
    bit ok;
    int req_cycles, pulses, pulse_at;
    do_reset();
    do_write(1, 1, 1'b1);
    wait_req(80, ok);
    total++; if (ok !== 1'b1 || {bus.req_row, bus.req_col} !== {3'd1, 3'd1}) begin bad++; $display("FAIL tmo_first_req got=(%0d,%0d) ok=%0b want=(1,1)", bus.req_row, bus.req_col, ok); end
    req_cycles = 0;
    pulses = 0;
    pulse_at = 0;
    for (int i = 0; i < 40 && bus.req === 1'b1; i++) begin
      req_cycles++;
      if (bus.timeout_err === 1'b1) begin
        pulses++;
        pulse_at = req_cycles;
      end
      @(negedge clk);
    end
    total++; if (req_cycles !== 15) begin bad++; $display("FAIL tmo_req_cycles got=%0d want=15", req_cycles); end
    total++; if (pulses !== 1 || pulse_at !== 15) begin bad++; $display("FAIL tmo_pulse got=%0d at=%0d want=1 at=15", pulses, pulse_at); end
    total++; if (bus.ix[9] !== 1'b1 || bus.pending_cnt !== 7'd1) begin bad++; $display("FAIL tmo_bit_kept got=%0b cnt=%0d want=1 cnt=1", bus.ix[9], bus.pending_cnt); end
    wait_req(80, ok);
    total++; if (ok !== 1'b1 || {bus.req_row, bus.req_col} !== {3'd1, 3'd1}) begin bad++; $display("FAIL tmo_reraise got=(%0d,%0d) ok=%0b want=(1,1)", bus.req_row, bus.req_col, ok); end
    ack_now();
    total++; if (bus.pending_cnt !== 7'd0) begin bad++; $display("FAIL tmo_cleanup got=%0d want=0", bus.pending_cnt); end
  endtask

  task automatic test_collision;
    bit ok;
    do_reset();
    do_write(4, 4, 1'b1);
    wait_req(80, ok);
    total++; if (ok !== 1'b1 || {bus.req_row, bus.req_col} !== {3'd4, 3'd4}) begin bad++; $display("FAIL coll_req got=(%0d,%0d) ok=%0b want=(4,4)", bus.req_row, bus.req_col, ok); end
    bus.wr_valid = 1'b1;
    bus.wr_row   = 3'd4;
    bus.wr_col   = 3'd4;
    bus.wr_set   = 1'b0;
    #1;
    total++; if (bus.wr_ready !== 1'b0) begin bad++; $display("FAIL coll_clear_blocked got=%0b want=0", bus.wr_ready); end
    bus.wr_col = 3'd5;
    #1;
    total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL coll_other_cell got=%0b want=1", bus.wr_ready); end
    bus.wr_col = 3'd4;
    @(posedge clk);
    #1;
    total++; if (bus.ix[36] !== 1'b1 || bus.req !== 1'b1) begin bad++; $display("FAIL coll_bit_held got=%0b req=%0b want=1 req=1", bus.ix[36], bus.req); end
    bus.wr_set = 1'b1;
    bus.ack    = 1'b1;
    @(posedge clk);
    #1;
    bus.wr_valid = 1'b0;
    bus.ack      = 1'b0;
    total++; if (bus.ix[36] !== 1'b1 || bus.pending_cnt !== 7'd1 || bus.req !== 1'b0) begin bad++; $display("FAIL coll_set_wins got=%0b cnt=%0d req=%0b want=1 cnt=1 req=0", bus.ix[36], bus.pending_cnt, bus.req); end
    wait_req(80, ok);
    total++; if (ok !== 1'b1 || {bus.req_row, bus.req_col} !== {3'd4, 3'd4}) begin bad++; $display("FAIL coll_reraise got=(%0d,%0d) ok=%0b want=(4,4)", bus.req_row, bus.req_col, ok); end
    ack_now();
    total++; if (bus.ix !== 64'h0) begin bad++; $display("FAIL coll_cleanup got=%h want=0", bus.ix); end
  endtask

  task automatic test_idle;
    int seen;
    do_reset();
    bus.ack = 1'b1;
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus.req !== 1'b0 || bus.timeout_err !== 1'b0) seen++;
    end
    bus.ack = 1'b0;
    total++; if (seen !== 0) begin bad++; $display("FAIL idle_no_req got=%0d want=0", seen); end
    total++; if (bus.pending_cnt !== 7'd0) begin bad++; $display("FAIL idle_pending got=%0d want=0", bus.pending_cnt); end
  endtask

  task automatic test_midreset;
    bit ok;
    do_reset();
    do_write(6, 2, 1'b1);
    do_write(7, 0, 1'b1);
    wait_req(80, ok);
    total++; if (ok !== 1'b1 || {bus.req_row, bus.req_col} !== {3'd6, 3'd2}) begin bad++; $display("FAIL mid_req got=(%0d,%0d) ok=%0b want=(6,2)", bus.req_row, bus.req_col, ok); end
    total++; if (bus.pending_cnt !== 7'd2) begin bad++; $display("FAIL mid_pending_2 got=%0d want=2", bus.pending_cnt); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.req !== 1'b0) begin bad++; $display("FAIL mid_req_async got=%0b want=0", bus.req); end
    total++; if (bus.ix !== 64'h0 || bus.pending_cnt !== 7'd0) begin bad++; $display("FAIL mid_ix_clear got=%h cnt=%0d want=0 cnt=0", bus.ix, bus.pending_cnt); end
    total++; if (bus.wr_ready !== 1'b0) begin bad++; $display("FAIL mid_wr_ready got=%0b want=0", bus.wr_ready); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    total++; if (bus.req !== 1'b0 || bus.wr_ready !== 1'b1) begin bad++; $display("FAIL mid_after_release req=%0b rdy=%0b want req=0 rdy=1", bus.req, bus.wr_ready); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_raster();
    test_timeout();
    test_collision();
    test_idle();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
